// File: rtl/wb_stage_pkg.sv
// rtl/wb_stage_pkg.sv - shared widths, write-back class encodings and convolution FIFO entry type
package wb_stage_pkg;
    localparam int LENGTH          = 16;
    localparam int INT8            = 8;
    localparam int INT32           = 32;
    localparam int VW              = LENGTH * INT8;
    localparam int CONV_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        WB_NONE   = 2'b00,
        WB_SCALAR = 2'b01,
        WB_VECTOR = 2'b10,
        WB_RSVD   = 2'b11
    } wb_class_e;

    typedef struct packed {
        logic [4:0]    addr;
        logic [VW-1:0] data;
    } conv_entry_t;
endpackage

// File: rtl/wb_stage_conv_wb_fifo.sv
// rtl/wb_stage_conv_wb_fifo.sv - synchronous FIFO buffering convolution results behind pipeline writes
module conv_wb_fifo
    import wb_stage_pkg::*;
#(
    parameter  int DEPTH = CONV_FIFO_DEPTH,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  conv_entry_t   wdata,
    output conv_entry_t   rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    conv_entry_t   mem_q [DEPTH];
    conv_entry_t   mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_pop   = pop && !empty;
        // a full FIFO still accepts a push when the head leaves in the same cycle
        do_push  = push && (!full || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - write-back steering into scalar/vector RF ports; WB_CONV_FIFO_EN buffers colliding convolution results
module wb_stage
    import wb_stage_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       opcode,
    input  logic [4:0]       rD,
    input  logic [1:0]       wb,
    input  logic             ldr,
    input  logic [INT32-1:0] s_result,
    input  logic [VW-1:0]    v_result,
    input  logic [INT32-1:0] smem,
    input  logic [VW-1:0]    vmem,
    input  logic             conv_write,
    input  logic [4:0]       conv_addr,
    input  logic [VW-1:0]    conv_result,
    output logic             s_we,
    output logic [4:0]       s_waddr,
    output logic [INT32-1:0] s_wdata,
    output logic             v_we,
    output logic [4:0]       v_waddr,
    output logic [VW-1:0]    v_wdata,
    output logic             conv_full,
    output logic             conv_pending,
    output logic             conv_overflow,
    output logic             wb_illegal
);
    logic             s_we_q, s_we_d;
    logic [4:0]       s_waddr_q, s_waddr_d;
    logic [INT32-1:0] s_wdata_q, s_wdata_d;
    logic             v_we_q, v_we_d;
    logic [4:0]       v_waddr_q, v_waddr_d;
    logic [VW-1:0]    v_wdata_q, v_wdata_d;
    logic             wb_illegal_q, wb_illegal_d;
    logic             pv;
    logic             unused_opcode;

    assign pv            = (wb == WB_VECTOR);
    assign unused_opcode = ^opcode;

`ifdef WB_CONV_FIFO_EN
    conv_entry_t fifo_head;
    logic        fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic        conv_overflow_q, conv_overflow_d;
    logic [$clog2(CONV_FIFO_DEPTH):0] fifo_count_unused;

    assign fifo_pop  = !pv && !fifo_empty;
    assign fifo_push = conv_write && (pv || !fifo_empty);

    conv_wb_fifo #(.DEPTH(CONV_FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata ('{addr: conv_addr, data: conv_result}),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count_unused)
    );

    assign conv_full     = fifo_full;
    assign conv_pending  = !fifo_empty;
    assign conv_overflow = conv_overflow_q;
`else
    // without buffering, upstream holds the result while a pipeline write owns the port
    assign conv_full     = conv_write && pv;
    assign conv_pending  = 1'b0;
    assign conv_overflow = 1'b0;
`endif

    always_comb begin
        s_we_d       = (wb == WB_SCALAR);
        s_waddr_d    = s_we_d ? rD : 5'd0;
        s_wdata_d    = s_we_d ? (ldr ? smem : s_result) : '0;
        v_we_d       = 1'b0;
        v_waddr_d    = 5'd0;
        v_wdata_d    = '0;
        wb_illegal_d = (wb == WB_RSVD);
        if (pv) begin
            v_we_d    = 1'b1;
            v_waddr_d = rD;
            v_wdata_d = ldr ? vmem : v_result;
`ifdef WB_CONV_FIFO_EN
        end else if (!fifo_empty) begin
            v_we_d    = 1'b1;
            v_waddr_d = fifo_head.addr;
            v_wdata_d = fifo_head.data;
`endif
        end else if (conv_write) begin
            v_we_d    = 1'b1;
            v_waddr_d = conv_addr;
            v_wdata_d = conv_result;
        end
`ifdef WB_CONV_FIFO_EN
        conv_overflow_d = conv_overflow_q || (conv_write && pv && fifo_full);
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_we_q       <= 1'b0;
            s_waddr_q    <= 5'd0;
            s_wdata_q    <= '0;
            v_we_q       <= 1'b0;
            v_waddr_q    <= 5'd0;
            v_wdata_q    <= '0;
            wb_illegal_q <= 1'b0;
`ifdef WB_CONV_FIFO_EN
            conv_overflow_q <= 1'b0;
`endif
        end else begin
            s_we_q       <= s_we_d;
            s_waddr_q    <= s_waddr_d;
            s_wdata_q    <= s_wdata_d;
            v_we_q       <= v_we_d;
            v_waddr_q    <= v_waddr_d;
            v_wdata_q    <= v_wdata_d;
            wb_illegal_q <= wb_illegal_d;
`ifdef WB_CONV_FIFO_EN
            conv_overflow_q <= conv_overflow_d;
`endif
        end
    end

    assign s_we       = s_we_q;
    assign s_waddr    = s_waddr_q;
    assign s_wdata    = s_wdata_q;
    assign v_we       = v_we_q;
    assign v_waddr    = v_waddr_q;
    assign v_wdata    = v_wdata_q;
    assign wb_illegal = wb_illegal_q;
endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - directed self-checking bench for wb_stage
module tb_wb_stage;
    import wb_stage_pkg::*;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       opcode;
    logic [4:0]       rD;
    logic [1:0]       wb;
    logic             ldr;
    logic [INT32-1:0] s_result, smem;
    logic [VW-1:0]    v_result, vmem;
    logic             conv_write;
    logic [4:0]       conv_addr;
    logic [VW-1:0]    conv_result;
    logic             s_we, v_we;
    logic [4:0]       s_waddr, v_waddr;
    logic [INT32-1:0] s_wdata;
    logic [VW-1:0]    v_wdata;
    logic             conv_full, conv_pending, conv_overflow, wb_illegal;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .rD            (rD),
        .wb            (wb),
        .ldr           (ldr),
        .s_result      (s_result),
        .v_result      (v_result),
        .smem          (smem),
        .vmem          (vmem),
        .conv_write    (conv_write),
        .conv_addr     (conv_addr),
        .conv_result   (conv_result),
        .s_we          (s_we),
        .s_waddr       (s_waddr),
        .s_wdata       (s_wdata),
        .v_we          (v_we),
        .v_waddr       (v_waddr),
        .v_wdata       (v_wdata),
        .conv_full     (conv_full),
        .conv_pending  (conv_pending),
        .conv_overflow (conv_overflow),
        .wb_illegal    (wb_illegal)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        wb         = 2'b00;
        ldr        = 1'b0;
        rD         = 5'd0;
        conv_write = 1'b0;
        conv_addr  = 5'd0;
    endtask

    function automatic logic [VW-1:0] vpat(input logic [7:0] b);
        return {LENGTH{b}};
    endfunction

    initial begin
        reset       = 1'b0;
        opcode      = 5'd0;
        s_result    = '0;
        smem        = '0;
        v_result    = '0;
        vmem        = '0;
        conv_result = '0;
        idle();
        tick();
        tick();
        check("rst_s_we", s_we, 0);
        check("rst_s_wdata", s_wdata, 0);
        check("rst_v_we", v_we, 0);
        check("rst_v_wdata", v_wdata, 0);
        check("rst_full", conv_full, 0);
        check("rst_pending", conv_pending, 0);
        check("rst_overflow", conv_overflow, 0);
        check("rst_illegal", wb_illegal, 0);
        reset = 1'b1;

        // scalar load, then scalar ALU result
        wb = WB_SCALAR; ldr = 1'b1; rD = 5'd3; smem = 32'hDEADBEEF; s_result = 32'h11111111;
        tick();
        check("sld_we", s_we, 1);
        check("sld_addr", s_waddr, 3);
        check("sld_data", s_wdata, 32'hDEADBEEF);
        check("sld_v_we", v_we, 0);
        ldr = 1'b0; rD = 5'd9; s_result = 32'h12345678;
        tick();
        check("salu_addr", s_waddr, 9);
        check("salu_data", s_wdata, 32'h12345678);
        idle();
        tick();
        check("sidle_we", s_we, 0);

        // direct convolution bypass
        conv_write = 1'b1; conv_addr = 5'd7; conv_result = vpat(8'hA5);
        tick();
        check("dconv_we", v_we, 1);
        check("dconv_addr", v_waddr, 7);
        check("dconv_data", v_wdata, vpat(8'hA5));
        check("dconv_pending", conv_pending, 0);

        // vector load
        idle();
        wb = WB_VECTOR; ldr = 1'b1; rD = 5'd4; vmem = vpat(8'hD4); v_result = vpat(8'h01);
        tick();
        check("vld_addr", v_waddr, 4);
        check("vld_data", v_wdata, vpat(8'hD4));

        // illegal class
        idle();
        wb = WB_RSVD;
        tick();
        check("ill_pulse", wb_illegal, 1);
        check("ill_s_we", s_we, 0);
        check("ill_v_we", v_we, 0);
        idle();
        tick();
        check("ill_clear", wb_illegal, 0);

`ifdef WB_CONV_FIFO_EN
        // collision: pipeline first, buffered conv next
        wb = WB_VECTOR; rD = 5'd2; v_result = vpat(8'hBB);
        conv_write = 1'b1; conv_addr = 5'd5; conv_result = vpat(8'hCC);
        tick();
        check("col_addr0", v_waddr, 2);
        check("col_data0", v_wdata, vpat(8'hBB));
        check("col_pending0", conv_pending, 1);
        idle();
        tick();
        check("col_we1", v_we, 1);
        check("col_addr1", v_waddr, 5);
        check("col_data1", v_wdata, vpat(8'hCC));
        check("col_pending1", conv_pending, 0);
        tick();
        check("col_idle", v_we, 0);

        // fill with four collisions
        for (int i = 0; i < 4; i++) begin
            wb = WB_VECTOR; rD = 5'(10 + i); v_result = vpat(8'(8'h10 + i));
            conv_write = 1'b1; conv_addr = 5'(20 + i); conv_result = vpat(8'(8'h20 + i));
            tick();
            check("fill_addr", v_waddr, 5'(10 + i));
            check("fill_data", v_wdata, vpat(8'(8'h10 + i)));
            check("fill_full", conv_full, (i == 3));
        end

        // full FIFO, push and pop together
        wb = WB_NONE; conv_write = 1'b1; conv_addr = 5'd31; conv_result = vpat(8'h31);
        tick();
        check("pp_addr", v_waddr, 20);
        check("pp_data", v_wdata, vpat(8'h20));
        check("pp_full", conv_full, 1);
        check("pp_overflow", conv_overflow, 0);

        // fifth conv against a full FIFO with a pipeline write is dropped
        wb = WB_VECTOR; rD = 5'd15; v_result = vpat(8'h15);
        conv_write = 1'b1; conv_addr = 5'd30; conv_result = vpat(8'h30);
        tick();
        check("ovf_addr", v_waddr, 15);
        check("ovf_flag", conv_overflow, 1);
        check("ovf_full", conv_full, 1);

        idle();
        for (int i = 0; i < 4; i++) begin
            logic [4:0] ea;
            logic [7:0] ed;
            ea = (i < 3) ? 5'(21 + i) : 5'd31;
            ed = (i < 3) ? 8'(8'h21 + i) : 8'h31;
            tick();
            check("drain_we", v_we, 1);
            check("drain_addr", v_waddr, ea);
            check("drain_data", v_wdata, vpat(ed));
            check("drain_full", conv_full, 0);
            check("drain_pending", conv_pending, (i < 3));
        end
        tick();
        check("drain_done", v_we, 0);
        check("ovf_sticky", conv_overflow, 1);

        // two entries queued, then reset
        for (int i = 0; i < 2; i++) begin
            wb = WB_VECTOR; rD = 5'(1 + i); v_result = vpat(8'(8'h41 + i));
            conv_write = 1'b1; conv_addr = 5'(8 + i); conv_result = vpat(8'(8'h51 + i));
            tick();
        end
        check("mrst_pre_pending", conv_pending, 1);
`else
        // no FIFO: upstream sees full during a collision and retries
        wb = WB_VECTOR; rD = 5'd2; v_result = vpat(8'hBB);
        conv_write = 1'b1; conv_addr = 5'd5; conv_result = vpat(8'hCC);
        #1;
        check("nf_full_col", conv_full, 1);
        tick();
        check("nf_addr0", v_waddr, 2);
        check("nf_data0", v_wdata, vpat(8'hBB));
        wb = WB_NONE;
        #1;
        check("nf_full_retry", conv_full, 0);
        tick();
        check("nf_addr1", v_waddr, 5);
        check("nf_data1", v_wdata, vpat(8'hCC));
        check("nf_pending", conv_pending, 0);
        check("nf_overflow", conv_overflow, 0);
        wb = WB_VECTOR; rD = 5'd1; v_result = vpat(8'h41); conv_write = 1'b0;
        tick();
        check("mrst_pre_we", v_we, 1);
`endif
        idle();
        #2;
        reset = 1'b0;
        #1;
        check("mrst_v_we", v_we, 0);
        check("mrst_v_addr", v_waddr, 0);
        check("mrst_s_we", s_we, 0);
        check("mrst_pending", conv_pending, 0);
        check("mrst_full", conv_full, 0);
        check("mrst_overflow", conv_overflow, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
        check("mrst_after_v_we", v_we, 0);
        check("mrst_after_s_we", s_we, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
